// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, FSM states
// and the word driven on a timed-out transaction.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INSTR,
        DRESP,
        IRESP
    } arb_state_t;

    localparam word_t ARB_ABORT_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request-unit and RAM handshake bundle seen by the arbiter.
// slave is the arbiter side, master the request unit / RAM side.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN,
        input  dmemaddr, dmemstore, ramload, ramstate,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN,
        output dmemaddr, dmemstore, ramload, ramstate,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/arb_req_latch.sv
// Holds address, write data and kind of the transaction in flight.
module arb_req_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t addr_d,
    input  word_t data_d,
    input  logic  write_d,
    output word_t addr,
    output word_t data,
    output logic  write
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            data  <= '0;
            write <= 1'b0;
        end else if (load) begin
            addr  <= addr_d;
            data  <= data_d;
            write <= write_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port, data first.
// MEM_ARB_TIMEOUT_EN enables the abort counter and arb_err.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.slave  bus,
    output logic             arb_err
);

    arb_state_t state;
    logic       ren;
    logic       wen;
    logic       ihit;
    logic       dhit;
    word_t      iload;
    word_t      dload;

    word_t      lat_addr;
    word_t      lat_data;
    logic       lat_write;

    logic       dreq;
    logic       load;

    assign dreq = bus.dmemWEN | bus.dmemREN;
    assign load = (state == IDLE) & (dreq | bus.imemREN);

    arb_req_latch u_latch (
        .clk     (CLK),
        .rst     (RST),
        .load    (load),
        .addr_d  (dreq ? bus.dmemaddr : bus.imemaddr),
        .data_d  (dreq ? bus.dmemstore : '0),
        .write_d (dreq & bus.dmemWEN),
        .addr    (lat_addr),
        .data    (lat_data),
        .write   (lat_write)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          err;

    assign arb_err = err;
`else
    assign arb_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ren   <= 1'b0;
            wen   <= 1'b0;
            ihit  <= 1'b0;
            dhit  <= 1'b0;
            iload <= '0;
            dload <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt   <= '0;
            err   <= 1'b0;
`endif
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err  <= 1'b0;
            cnt  <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (dreq) begin
                        state <= DATA;
                        wen   <= bus.dmemWEN;
                        ren   <= ~bus.dmemWEN;
                    end else if (bus.imemREN) begin
                        state <= INSTR;
                        ren   <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.ramstate == ACCESS) begin
                        state <= DRESP;
                        ren   <= 1'b0;
                        wen   <= 1'b0;
                        dhit  <= 1'b1;
                        if (!lat_write) dload <= bus.ramload;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (cnt == LAST) begin
                        state <= DRESP;
                        ren   <= 1'b0;
                        wen   <= 1'b0;
                        dhit  <= 1'b1;
                        err   <= 1'b1;
                        dload <= ARB_ABORT_WORD;
                    end else begin
                        cnt   <= cnt + 1'b1;
`endif
                    end
                end
                INSTR: begin
                    if (bus.ramstate == ACCESS) begin
                        state <= IRESP;
                        ren   <= 1'b0;
                        ihit  <= 1'b1;
                        iload <= bus.ramload;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (cnt == LAST) begin
                        state <= IRESP;
                        ren   <= 1'b0;
                        ihit  <= 1'b1;
                        err   <= 1'b1;
                        iload <= ARB_ABORT_WORD;
                    end else begin
                        cnt   <= cnt + 1'b1;
`endif
                    end
                end
                DRESP:   state <= IDLE;
                IRESP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = lat_addr;
    assign bus.ramstore = lat_data;
    assign bus.ihit     = ihit;
    assign bus.dhit     = dhit;
    assign bus.imemload = iload;
    assign bus.dmemload = dload;

endmodule
